snax_acc_csr_bank: RTL and testbench
====================================

SNAX_ACC_CSR_BANK -- requirements
Module: snax_acc_csr_bank

Interface
REQ-001 The block SHALL have parameter DataWidth, default 32, meaning CSR and data width.
REQ-002 The block SHALL have parameter AddrWidth, default 32, meaning the width of the CSR index (already offset-corrected upstream).
REQ-003 The block SHALL have parameter NumRwCsr, default 8, meaning the number of read/write config CSRs.
REQ-004 Ports SHALL be, one per line:
  clk_i  in  1  clock; one clock domain.
  rst_i  in  1  reset; synchronous and active-high.
  acc_req_addr_i  in  AddrWidth  CSR index.
  acc_req_data_i  in  DataWidth  write data.
  acc_req_wen_i  in  1  write enable.
  acc_req_valid_i  in  1  request valid.
  acc_req_ready_o  out  1  request ready.
  acc_rsp_data_o  out  DataWidth  read data (pre-write value).
  acc_rsp_valid_o  out  1  response valid.
  acc_rsp_ready_i  in  1  response ready.
  csr_o  out  NumRwCsr*DataWidth  flat RW CSR contents; CSR k at bits [k*DataWidth +: DataWidth].
  start_o  out  1  single-cycle accelerator start pulse.
  busy_i  in  1  accelerator busy status.

Function
REQ-005 Address map SHALL be: 0..NumRwCsr-1 RW CSRs; NumRwCsr STATUS; NumRwCsr+1 PERF; any other index out of range.
REQ-006 The request is accepted on a cycle when acc_req_valid_i and acc_req_ready_o are both 1.
REQ-007 acc_req_ready_o SHALL be !acc_rsp_valid_o || acc_rsp_ready_i, so the response slot is one deep and back-to-back requests run at full throughput.
REQ-008 Each accepted request SHALL produce exactly one response; acc_rsp_valid_o SHALL rise on the cycle after acceptance, giving 1-cycle latency.
REQ-009 acc_rsp_data_o and acc_rsp_valid_o SHALL hold stable while acc_rsp_valid_o is 1 and acc_rsp_ready_i is 0.
REQ-010 Response data SHALL be the CSR value before any write made by the same request.
REQ-011 For a RW CSR with wen=1, the new value SHALL be visible on csr_o on the cycle after acceptance.
REQ-012 Reading STATUS SHALL return {0..., busy_i} as sampled at acceptance.
REQ-013 On a STATUS write, bit0=1 together with busy_i=0 SHALL assert start_o for exactly one cycle, on the cycle after acceptance.
REQ-014 A STATUS write with busy_i=1 SHALL be dropped, with no start pulse.
REQ-015 All other STATUS bits, and all PERF writes, SHALL be ignored.
REQ-016 Out-of-range accesses SHALL read 0, SHALL leave state unchanged, and SHALL still produce a response.
REQ-017 A request with wen=0 SHALL be a pure read.

Reset
REQ-018 While rst_i=1 at a clock edge, the following SHALL be cleared: all RW CSRs, acc_rsp_valid_o, acc_rsp_data_o, start_o, and the perf counter.
REQ-019 acc_req_ready_o SHALL be 1 after reset.
REQ-020 Reset during a pending response SHALL drop that response silently.

Configuration
REQ-021 With macro SNAX_CSR_PERF_CNT_EN defined, PERF SHALL be a DataWidth counter with this behaviour:
  - increments on every cycle with busy_i=1;
  - saturates at all-ones;
  - clears to 0 on the cycle start_o is asserted, where clear takes priority over increment.
REQ-022 With SNAX_CSR_PERF_CNT_EN undefined, no counter logic SHALL exist and PERF SHALL read 0.

Structure
REQ-023 A shared package snax_csr_pkg SHALL hold the STATUS and PERF index offsets, the STATUS bit positions (BusyBit=0, StartBit=0), and a csr_rsp_t typedef {data}.
REQ-024 One sub-module snax_csr_rsp_reg SHALL implement the one-deep valid/ready response register; all remaining logic stays in the top module.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
  - Write 0xDEADBEEF to CSR 3 then read CSR 3 -> responses 0x0 then 0xDEADBEEF; csr_o slice 3 = 0xDEADBEEF one cycle after the first acceptance.
  - Back-to-back writes to CSRs 0..7 with acc_rsp_ready_i held at 1 -> 8 responses on 8 consecutive cycles; acc_req_ready_o stays 1.
  - Hold acc_rsp_ready_i=0 for 5 cycles after a request -> acc_req_ready_o=0 and response data stable; release -> next request is accepted in the same cycle.
  - STATUS write of 0x1 with busy_i=0 -> start_o high for exactly 1 cycle; repeat with busy_i=1 -> no pulse.
  - Access to index NumRwCsr+5 -> response 0x0 and no CSR change.
  - With SNAX_CSR_PERF_CNT_EN defined: start, then busy_i=1 for 10 cycles -> PERF reads 10; a new start resets the count to 0. With the macro undefined, PERF reads 0.

Source files
------------

// File: rtl/snax_csr_pkg.sv
// snax_csr_pkg: shared CSR bank indices, bit positions and response type.
// Optional perf counter in the bank is enabled by SNAX_CSR_PERF_CNT_EN.
package snax_csr_pkg;

  localparam int unsigned StatusOffset = 0;
  localparam int unsigned PerfOffset   = 1;

  localparam int unsigned BusyBit  = 0;
  localparam int unsigned StartBit = 0;

  localparam int unsigned CsrDataWidth = 32;

  typedef struct packed {
    logic [CsrDataWidth-1:0] data;
  } csr_rsp_t;

endpackage

// File: rtl/snax_csr_rsp_reg.sv
// snax_csr_rsp_reg: one-deep valid/ready response holding register.
// Generic over the response payload type.
module snax_csr_rsp_reg
  import snax_csr_pkg::*;
#(
  parameter type rsp_t = csr_rsp_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  rsp_t in_rsp_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output rsp_t out_rsp_o
);

  logic valid_q;
  rsp_t rsp_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_rsp_o   = rsp_q;

  // load on accept, drop valid once drained
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      rsp_q   <= '0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      rsp_q   <= in_rsp_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/snax_acc_csr_bank.sv
// snax_acc_csr_bank: RW config CSRs, STATUS/start and PERF for an accelerator.
// Define SNAX_CSR_PERF_CNT_EN to build the busy-cycle perf counter.
module snax_acc_csr_bank
  import snax_csr_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned NumRwCsr  = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [AddrWidth-1:0]          acc_req_addr_i,
  input  logic [DataWidth-1:0]          acc_req_data_i,
  input  logic                          acc_req_wen_i,
  input  logic                          acc_req_valid_i,
  output logic                          acc_req_ready_o,
  output logic [DataWidth-1:0]          acc_rsp_data_o,
  output logic                          acc_rsp_valid_o,
  input  logic                          acc_rsp_ready_i,
  output logic [NumRwCsr*DataWidth-1:0] csr_o,
  output logic                          start_o,
  input  logic                          busy_i
);

  localparam int unsigned IdxW =
    (NumRwCsr > 1) ? $clog2(NumRwCsr) : 1;

  localparam logic [AddrWidth-1:0] RwLimit =
    AddrWidth'(NumRwCsr);
  localparam logic [AddrWidth-1:0] StatusIdx =
    AddrWidth'(NumRwCsr + StatusOffset);
  localparam logic [AddrWidth-1:0] PerfIdx =
    AddrWidth'(NumRwCsr + PerfOffset);

  typedef struct packed {
    logic [DataWidth-1:0] data;
  } rsp_t;

  logic [DataWidth-1:0] csr_q [NumRwCsr];
  logic [DataWidth-1:0] rd_data;
  logic [DataWidth-1:0] perf_val;
  logic [IdxW-1:0]      idx;
  logic accept;
  logic is_rw;
  logic is_status;
  logic is_perf;
  logic start_q;
  rsp_t rsp_in;
  rsp_t rsp_out;

  assign idx       = acc_req_addr_i[IdxW-1:0];
  assign accept    = acc_req_valid_i && acc_req_ready_o;
  assign is_rw     = acc_req_addr_i < RwLimit;
  assign is_status = acc_req_addr_i == StatusIdx;
  assign is_perf   = acc_req_addr_i == PerfIdx;

  // RW config registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NumRwCsr; k++) begin
        csr_q[k] <= '0;
      end
    end else if (accept && acc_req_wen_i && is_rw) begin
      csr_q[idx] <= acc_req_data_i;
    end
  end

  // start pulse only when the accelerator is idle at acceptance
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_q <= 1'b0;
    end else begin
      start_q <= accept && acc_req_wen_i && is_status &&
                 acc_req_data_i[StartBit] && !busy_i;
    end
  end

  assign start_o = start_q;

`ifdef SNAX_CSR_PERF_CNT_EN
  logic [DataWidth-1:0] perf_q;

  // busy-cycle counter, cleared by start, saturating
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else if (start_q) begin
      perf_q <= '0;
    end else if (busy_i && (perf_q != '1)) begin
      perf_q <= perf_q + 1'b1;
    end
  end

  assign perf_val = perf_q;
`else
  assign perf_val = '0;
`endif

  // read mux: value before this request's write
  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      is_rw:     rd_data = csr_q[idx];
      is_status: rd_data[BusyBit] = busy_i;
      is_perf:   rd_data = perf_val;
      default:   rd_data = '0;
    endcase
  end

  // flatten config registers
  always_comb begin
    csr_o = '0;
    for (int k = 0; k < NumRwCsr; k++) begin
      csr_o[k*DataWidth +: DataWidth] = csr_q[k];
    end
  end

  assign rsp_in.data = rd_data;

  snax_csr_rsp_reg #(
    .rsp_t (rsp_t)
  ) i_rsp_reg (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (acc_req_valid_i),
    .in_ready_o  (acc_req_ready_o),
    .in_rsp_i    (rsp_in),
    .out_valid_o (acc_rsp_valid_o),
    .out_ready_i (acc_rsp_ready_i),
    .out_rsp_o   (rsp_out)
  );

  assign acc_rsp_data_o = rsp_out.data;

endmodule

// File: tb/tb_snax_acc_csr_bank.sv
// tb_snax_acc_csr_bank: scoreboard bench for the accelerator CSR bank.
// Honours SNAX_CSR_PERF_CNT_EN to pick the PERF expectations.
module tb_snax_acc_csr_bank;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [AW-1:0] acc_req_addr_i = '0;
  logic [DW-1:0] acc_req_data_i = '0;
  logic          acc_req_wen_i = 1'b0;
  logic          acc_req_valid_i = 1'b0;
  logic          acc_req_ready_o;
  logic [DW-1:0] acc_rsp_data_o;
  logic          acc_rsp_valid_o;
  logic          acc_rsp_ready_i = 1'b1;
  logic [N*DW-1:0] csr_o;
  logic          start_o;
  logic          busy_i = 1'b0;

  snax_acc_csr_bank #(
    .DataWidth (DW),
    .AddrWidth (AW),
    .NumRwCsr  (N)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .acc_req_addr_i  (acc_req_addr_i),
    .acc_req_data_i  (acc_req_data_i),
    .acc_req_wen_i   (acc_req_wen_i),
    .acc_req_valid_i (acc_req_valid_i),
    .acc_req_ready_o (acc_req_ready_o),
    .acc_rsp_data_o  (acc_rsp_data_o),
    .acc_rsp_valid_o (acc_rsp_valid_o),
    .acc_rsp_ready_i (acc_rsp_ready_i),
    .csr_o           (csr_o),
    .start_o         (start_o),
    .busy_i          (busy_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state
  logic [DW-1:0] mem     [N];
  logic [DW-1:0] mem_nxt [N];
  logic [DW-1:0] perf_m = '0;
  logic [DW-1:0] exp_q [$];
  bit exp_start = 0;
  bit start_req = 0;
  bit acc_flag  = 0;
  bit acc_prev  = 0;
  bit rand_mode = 0;
  bit dir_rr    = 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*DW-1:0] flat();
    logic [N*DW-1:0] f;
    for (int k = 0; k < N; k++) f[k*DW +: DW] = mem[k];
    return f;
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    if (a < N) return mem[a];
    if (a == N) return {{(DW-1){1'b0}}, busy_i};
`ifdef SNAX_CSR_PERF_CNT_EN
    if (a == N + 1) return perf_m;
`endif
    return '0;
  endfunction

  function automatic void ref_write(input logic [AW-1:0] a,
                                    input logic [DW-1:0] d,
                                    input logic w);
    if (!w) return;
    if (a < N) mem_nxt[a] = d;
    else if (a == N && d[0] && !busy_i) start_req = 1;
  endfunction

  // cycle-level reference: registers advance on each rising edge
  always @(posedge clk) begin
    if (rst_i) begin
      for (int k = 0; k < N; k++) begin
        mem[k] = '0;
        mem_nxt[k] = '0;
      end
      perf_m = '0;
      exp_start = 0;
      start_req = 0;
      acc_prev = 0;
      acc_flag = 0;
    end else begin
      if (exp_start) perf_m = '0;
      else if (busy_i && perf_m != {DW{1'b1}}) perf_m = perf_m + 1;
      exp_start = start_req;
      start_req = 0;
      for (int k = 0; k < N; k++) mem[k] = mem_nxt[k];
      acc_prev = acc_flag;
      acc_flag = 0;
    end
  end

  // monitor: samples late in each cycle, after the driver settled
  bit            hold = 0;
  logic [DW-1:0] hold_data = '0;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_i) begin
        hold = 0;
      end else begin
        chk("start_o", start_o, exp_start);
        n_checks++;
        if (csr_o !== flat()) begin
          n_fail++;
          $display("FAIL csr_o: got %h want %h", csr_o, flat());
        end
        if (acc_prev) chk("rsp_latency", acc_rsp_valid_o, 1);
        if (hold) begin
          chk("hold_valid", acc_rsp_valid_o, 1);
          chk("hold_data", acc_rsp_data_o, hold_data);
        end
        if (acc_rsp_valid_o && acc_rsp_ready_i) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", acc_rsp_valid_o, 0);
          end else begin
            chk("rsp_data", acc_rsp_data_o, exp_q.pop_front());
          end
        end
        hold = acc_rsp_valid_o && !acc_rsp_ready_i;
        hold_data = acc_rsp_data_o;
      end
    end
  end

  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic w, input bit has_exp,
                      input logic [DW-1:0] ev, output int waited);
    logic [DW-1:0] e;
    @(negedge clk);
    if (rand_mode) begin
      busy_i = ($urandom_range(0, 3) == 0);
      acc_rsp_ready_i = ($urandom_range(0, 3) != 0);
    end else begin
      acc_rsp_ready_i = dir_rr;
    end
    acc_req_addr_i = a;
    acc_req_data_i = d;
    acc_req_wen_i = w;
    acc_req_valid_i = 1'b1;
    waited = 0;
    #1;
    while (!acc_req_ready_o && waited < 50) begin
      @(negedge clk);
      if (rand_mode) acc_rsp_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      waited++;
    end
    if (!acc_req_ready_o) begin
      chk("accept_timeout", acc_req_ready_o, 1);
      acc_req_valid_i = 1'b0;
      return;
    end
    e = has_exp ? ev : ref_read(a);
    exp_q.push_back(e);
    ref_write(a, d, w);
    acc_flag = 1;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      acc_req_valid_i = 1'b0;
      acc_rsp_ready_i = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    acc_req_valid_i = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  int w;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("rst_ready", acc_req_ready_o, 1);
    chk("rst_rsp_valid", acc_rsp_valid_o, 0);
    chk("rst_rsp_data", acc_rsp_data_o, 0);
    chk("rst_start", start_o, 0);
    chk("rst_csr_lo", csr_o[63:0], 0);

    // write then read CSR 3
    send(3, 32'hDEADBEEF, 1, 1, 32'h0, w);
    send(3, 32'h0, 0, 1, 32'hDEADBEEF, w);
    idle(2);

    // back-to-back writes at full throughput
    for (int k = 0; k < N; k++) begin
      send(k, 32'h1000 + k, 1, 0, 0, w);
      chk("b2b_no_stall", w, 0);
    end
    idle(2);

    // response backpressure
    dir_rr = 0;
    send(5, 32'h0, 0, 1, 32'h1005, w);
    repeat (5) begin
      @(negedge clk);
      acc_req_valid_i = 1'b0;
      #1;
      chk("bp_ready_low", acc_req_ready_o, 0);
    end
    dir_rr = 1;
    send(6, 32'h0, 0, 1, 32'h1006, w);
    chk("bp_release_accept", w, 0);
    idle(2);

    // start pulse, then dropped start while busy
    busy_i = 0;
    send(N, 32'h1, 1, 1, 32'h0, w);
    @(negedge clk);
    acc_req_valid_i = 1'b0;
    #1;
    chk("start_pulse", start_o, 1);
    @(negedge clk);
    #1;
    chk("start_single", start_o, 0);
    busy_i = 1;
    send(N, 32'h1, 1, 1, 32'h1, w);
    @(negedge clk);
    acc_req_valid_i = 1'b0;
    #1;
    chk("no_start_busy", start_o, 0);
    busy_i = 0;
    idle(2);

    // out of range
    send(N + 5, 32'h12345678, 1, 1, 32'h0, w);
    send(N + 5, 32'h0, 0, 1, 32'h0, w);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 32'h0, w);
    idle(2);

`ifdef SNAX_CSR_PERF_CNT_EN
    send(N, 32'h1, 1, 1, 32'h0, w);
    idle(2);
    @(negedge clk);
    busy_i = 1;
    repeat (10) @(negedge clk);
    busy_i = 0;
    send(N + 1, 32'h0, 0, 1, 32'd10, w);
    send(N, 32'h1, 1, 1, 32'h0, w);
    idle(2);
    send(N + 1, 32'h0, 0, 1, 32'd0, w);
    idle(2);
`else
    busy_i = 1;
    idle(3);
    busy_i = 0;
    send(N + 1, 32'h0, 0, 1, 32'd0, w);
    idle(2);
`endif

    // reset drops a pending response
    dir_rr = 0;
    send(2, 32'h0, 0, 0, 0, w);
    do_reset();
    #1;
    chk("rst_drop_valid", acc_rsp_valid_o, 0);
    chk("rst_drop_ready", acc_req_ready_o, 1);
    chk("rst_drop_csr", csr_o[127:64], 0);
    dir_rr = 1;

    // randomized traffic
    rand_mode = 1;
    for (int i = 0; i < 300; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 15) == 0) ? $urandom()
                                       : AW'($urandom_range(0, N + 3));
      send(a, $urandom(), 1'($urandom_range(0, 1)), 0, 0, w);
    end
    rand_mode = 0;
    idle(1);
    busy_i = 0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("drain_empty", exp_q.size(), 0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
